// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants and helpers for the board GPIO front-end
// Purpose: default parameter values for the board I/O blocks and the
//          debounce counter width helper.
package board_io_pkg;

    localparam int SW_WIDTH_DEF        = 8;
    localparam int LED_WIDTH_DEF       = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 100000;
    localparam int PWM_BITS_DEF        = 4;

    // Short debounce window so simulations reach acceptance in a few cycles.
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/board_gpio_frontend_sw_debounce.sv
// rtl/board_gpio_frontend_sw_debounce.sv - single-bit switch synchroniser and debouncer
// Purpose: two-flop synchroniser, stability counter and one-cycle change flag
//          for one switch pin.
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   pin_i     raw asynchronous switch pin
//   state_o   debounced switch state
//   accept_o  combinational: state_o updates on the coming edge
//   change_o  registered: high for one cycle after state_o changed
module sw_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic state_o,
    output logic accept_o,
    output logic change_o
);

    localparam int              CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             state_q;
    logic             state_d;
    logic             change_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // Any cycle where the synchronised pin agrees with the accepted state
    // restarts the window, so a bounce never accumulates toward acceptance.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        accept  = 1'b0;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = sync2_q;
            cnt_d   = '0;
            accept  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= 1'b0;
            change_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            change_q <= accept;
            cnt_q    <= cnt_d;
        end
    end

    assign state_o  = state_q;
    assign accept_o = accept;
    assign change_o = change_q;

endmodule

// File: rtl/board_gpio_frontend.sv
// rtl/board_gpio_frontend.sv - board-side GPIO front-end for switches and LEDs
// Purpose: debounced switch inputs with change reporting toward the SoC
//          gpioA_read port, and registered LED drive from gpioA_write /
//          gpioA_writeEnable with optional global PWM dimming.
// Build option: BOARD_GPIO_PWM_EN compiles in the PWM counter, duty register
//               and LED gating; without it pwm_duty is ignored.
// Ports:
//   io_mainClk        system clock
//   io_asyncReset     asynchronous active-high reset
//   sw_pin            raw switch pins
//   gpio_read         debounced switch state
//   sw_change         one-cycle pulse when any debounced bit changed
//   sw_change_mask    bits that changed, zero outside the pulse
//   gpio_write        LED bits from the SoC
//   gpio_writeEnable  LED enables from the SoC
//   pwm_duty          global LED brightness
//   led_pin           registered LED drive
module board_gpio_frontend
    import board_io_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DEF,
    parameter int LED_WIDTH       = LED_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PWM_BITS        = PWM_BITS_DEF
) (
    input  logic                 io_mainClk,
    input  logic                 io_asyncReset,
    input  logic [SW_WIDTH-1:0]  sw_pin,
    output logic [SW_WIDTH-1:0]  gpio_read,
    output logic                 sw_change,
    output logic [SW_WIDTH-1:0]  sw_change_mask,
    input  logic [LED_WIDTH-1:0] gpio_write,
    input  logic [LED_WIDTH-1:0] gpio_writeEnable,
    input  logic [PWM_BITS-1:0]  pwm_duty,
    output logic [LED_WIDTH-1:0] led_pin
);

    logic [SW_WIDTH-1:0]  accept_vec;
    logic                 sw_change_q;
    logic [LED_WIDTH-1:0] led_q;
    logic [LED_WIDTH-1:0] led_d;
    logic                 pwm_on;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sw_debounce (
            .clk_i   (io_mainClk),
            .rst_i   (io_asyncReset),
            .pin_i   (sw_pin[i]),
            .state_o (gpio_read[i]),
            .accept_o(accept_vec[i]),
            .change_o(sw_change_mask[i])
        );
    end

    // Registered from the next-mask value so it lines up with sw_change_mask.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            sw_change_q <= 1'b0;
        end else begin
            sw_change_q <= |accept_vec;
        end
    end

`ifdef BOARD_GPIO_PWM_EN
    localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;

    // Duty is only picked up at the period boundary so a mid-period change
    // cannot produce a runt or stretched pulse.
    always_comb begin
        duty_d = duty_q;
        if (pwm_cnt_q == PWM_MAX) begin
            duty_d = pwm_duty;
        end
    end

    assign pwm_on = (duty_q == PWM_MAX) | (pwm_cnt_q < duty_q);

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            pwm_cnt_q <= '0;
            duty_q    <= PWM_MAX;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            duty_q    <= duty_d;
        end
    end
`else
    logic unused_pwm_duty;
    assign unused_pwm_duty = ^pwm_duty;
    assign pwm_on          = 1'b1;
`endif

    assign led_d = gpio_write & gpio_writeEnable & {LED_WIDTH{pwm_on}};

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign sw_change = sw_change_q;
    assign led_pin   = led_q;

endmodule

// File: doc/board_gpio_frontend.md
# board_gpio_frontend

Parametrised board-side GPIO front-end between the Murax SoC `gpioA` port and the physical switches and LEDs of the board top level. It synchronises and debounces `SW_WIDTH` switch inputs and reports debounced edges as a one-cycle change pulse with a bit mask. It drives `LED_WIDTH` LEDs from the SoC write and write-enable vectors, with optional global PWM dimming. It replaces the direct `sw`→`gpioA_read` and `gpioA_write`→`led` wiring in board top levels.

## Interface
Parameters:
- `SW_WIDTH`, 8, number of switch inputs (≥1)
- `LED_WIDTH`, 10, number of LED outputs (≥1)
- `DEBOUNCE_CYCLES`, 100000, consecutive stable cycles required to accept a switch change (≥1)
- `PWM_BITS`, 4, width of PWM counter and duty value (≥1)

Ports (one clock; reset is asynchronous and active-high):
- `io_mainClk`  in  1  system clock
- `io_asyncReset`  in  1  asynchronous active-high reset
- `sw_pin`  in  SW_WIDTH  raw, asynchronous switch pins
- `gpio_read`  out  SW_WIDTH  debounced switch state to SoC `gpioA_read`
- `sw_change`  out  1  one-cycle pulse, any debounced bit changed
- `sw_change_mask`  out  SW_WIDTH  bits that changed, valid while `sw_change` is high, zero otherwise
- `gpio_write`  in  LED_WIDTH  SoC `gpioA_write` LED bits
- `gpio_writeEnable`  in  LED_WIDTH  SoC `gpioA_writeEnable`; LED is lit only when its enable bit is 1
- `pwm_duty`  in  PWM_BITS  global LED brightness
- `led_pin`  out  LED_WIDTH  registered LED drive

## Operation
- Reset values: `gpio_read`=0, `sw_change`=0, `sw_change_mask`=0, `led_pin`=0. Internally: sync flops=0, debounce counters=0, `pwm_cnt`=0, `duty_q`=all-ones.
- Switch path, per bit:
  - Two-flop synchroniser, giving `s2`.
  - Counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == gpio_read[i]`: counter cleared to 0.
  - Otherwise, if counter == `DEBOUNCE_CYCLES-1`: `gpio_read[i] <= s2` and counter cleared to 0.
  - Otherwise: counter increments.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles clears the counter, and `gpio_read` does not change.
- Change flag, per bit: `sw_change_mask[i]` is registered on the same edge that updates `gpio_read[i]`, and is 1 only on that edge. `sw_change` is the OR of the next mask value, also registered.
- Simultaneous acceptance on several bits gives one pulse with all of those bits set. Acceptances on consecutive cycles give back-to-back pulses.
- Rising and falling changes are both reported; direction is read from `gpio_read`.
- LED path: `led_pin[j] <= gpio_write[j] & gpio_writeEnable[j] & pwm_on`. Without PWM, `pwm_on` = 1.
- Reset mid-debounce: all counters and state return to reset values immediately. After release, a held-high switch appears after the full latency.

## Timing
- Switch latency: for a pin change first captured by sync flop 1 at edge 0, `gpio_read` and `sw_change_mask`/`sw_change` update at edge `DEBOUNCE_CYCLES+1`, provided the pin stays stable throughout.
- LED latency: one cycle from `gpio_write`/`gpio_writeEnable` to `led_pin`.
- PWM:
  - `pwm_cnt` is free-running, increments every cycle and wraps at 2^PWM_BITS−1 → 0.
  - `duty_q <= pwm_duty` only on the cycle where `pwm_cnt` is all-ones (period boundary), so duty changes never glitch mid-period.
  - `pwm_on = (duty_q == all-ones) | (pwm_cnt < duty_q)`.
  - Duty 0 means always off. Duty k (0<k<max) means lit for k of 2^PWM_BITS cycles per period. All-ones means 100 %.

## Configuration
- `BOARD_GPIO_PWM_EN` defined: PWM counter, `duty_q` and the `pwm_on` gating are compiled in, as described above.
- Undefined: no PWM logic. `pwm_duty` is accepted and ignored, and `led_pin <= gpio_write & gpio_writeEnable`.
- Switch path is identical in both builds.

## Structure
- Shared package `board_io_pkg`:
  - default constants `SW_WIDTH_DEF`, `LED_WIDTH_DEF`, `DEBOUNCE_CYCLES_DEF`, `PWM_BITS_DEF`
  - a sim-friendly `DEBOUNCE_CYCLES_SIM` = 4
- One sub-module `sw_debounce`: single bit, containing the synchroniser, counter and change flag, parameter `DEBOUNCE_CYCLES`. It is generated `SW_WIDTH` times.
- The top module holds the mask/OR reduction and the LED/PWM logic.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `PWM_BITS`=4, `LED_WIDTH`=10, `SW_WIDTH`=8, and is run with and without `BOARD_GPIO_PWM_EN`.
- Reset: assert `io_asyncReset` with `sw_pin`=8'hFF → all outputs 0. Release → `gpio_read`=8'hFF at edge 5 after the first sample, with one `sw_change` pulse and mask 8'hFF.
- Bounce: toggle `sw_pin[2]` high for 3 cycles, low 1 cycle, high 4 cycles → no change on the 3-cycle glitch. `gpio_read[2]`=1 exactly 5 edges after the final rise, with mask 8'h04.
- Simultaneous: `sw_pin[0]` and `sw_pin[7]` rise on the same edge → single pulse, mask 8'h81. Later fall of `sw_pin[7]` only → pulse, mask 8'h80, `gpio_read`=8'h01.
- LED enable: `gpio_write`=10'h3FF, `gpio_writeEnable`=10'h155, PWM off → `led_pin`=10'h155 one cycle later.
- PWM: `pwm_duty`=4 → LEDs lit 4 of every 16 cycles, starting at the period after the boundary. Duty 0 → always 0. Duty 15 → always on. Change duty mid-period → old duty holds until `pwm_cnt` wraps.
- Mid-debounce reset: assert reset while a count is at 3 → no pulse. After release, full 5-cycle latency applies.
